// File: rtl/lotr_pkg.sv
// ============================================================================
// Module : lotr_pkg
// Brief  : Shared fabric opcodes, UART command FSM states and frame constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lotr_pkg;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DATA     = 3'd2,
    REQ      = 3'd3,
    WAIT_RSP = 3'd4,
    TX       = 3'd5
  } t_uart_cmd_state;

  localparam logic [7:0] UART_CMD_WR  = 8'h57;
  localparam logic [7:0] UART_CMD_RD  = 8'h52;
  localparam logic [7:0] UART_RPL_OK  = 8'h4B;
  localparam logic [7:0] UART_RPL_ERR = 8'h3F;
  localparam logic [7:0] UART_RPL_TMO = 8'h54;

endpackage

`default_nettype wire

// File: rtl/uart_reply_shifter.sv
// ============================================================================
// Module : uart_reply_shifter
// Brief  : Up-to-4-byte reply buffer, parallel load, MSB-first valid/ready drain.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_reply_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [2:0]  load_len,
  input  logic [31:0] load_bytes,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        last_accept,
  output logic        cmd_done
);

  logic [31:0] r_buf;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        r_done;
  logic        w_accept;

  assign w_accept    = r_valid && tx_ready;
  assign last_accept = w_accept && (r_cnt == 3'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= last_accept;
      if (load) begin
        r_buf   <= load_bytes;
        r_cnt   <= load_len;
        r_valid <= (load_len != 3'd0);
      end else if (w_accept) begin
        // Shift the next byte up into the output slot; zero-fill behind it.
        r_buf   <= {r_buf[23:0], 8'h00};
        r_cnt   <= r_cnt - 3'd1;
        r_valid <= !last_accept;
      end
    end
  end

  assign tx_valid = r_valid;
  assign tx_data  = r_buf[31:24];
  assign cmd_done = r_done;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_sequencer.sv
// ============================================================================
// Module : uart_cmd_sequencer
// Brief  : Parses UART W/R frames, issues one C2F request, streams reply bytes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_sequencer
  import lotr_pkg::*;
#(
  parameter int         BYTE_TIMEOUT = 200000,
  parameter int         RSP_TIMEOUT  = 1024,
  parameter logic [1:0] THREAD_ID    = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        C2F_ReqValidQ500H,
  output t_opcode     C2F_ReqOpcodeQ500H,
  output logic [31:0] C2F_ReqAddressQ500H,
  output logic [31:0] C2F_ReqDataQ500H,
  output logic [1:0]  C2F_ReqThreadIDQ500H,
  input  logic        C2F_RspValidQ502H,
  input  t_opcode     C2F_RspOpcodeQ502H,
  input  logic [31:0] C2F_RspDataQ502H,
  input  logic        C2F_RspStall,
  output logic        cmd_done,
  output logic        busy
);

  localparam int c_BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int c_RT_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [c_BT_W-1:0] c_BT_MAX  = c_BT_W'(BYTE_TIMEOUT);
  localparam logic [c_BT_W-1:0] c_BT_FIRE = c_BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [c_RT_W-1:0] c_RT_MAX  = c_RT_W'(RSP_TIMEOUT);
  localparam logic [c_RT_W-1:0] c_RT_FIRE = c_RT_W'(RSP_TIMEOUT - 1);

  t_uart_cmd_state   r_state;
  t_opcode           r_op;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_byte_cnt;
  logic [c_BT_W-1:0] r_byte_tmr;
  logic [c_RT_W-1:0] r_rsp_tmr;

  logic        w_rsp_match;
  logic        w_byte_tmo;
  logic        w_rsp_tmo;
  logic        w_req_fire;
  logic        w_tx_last;
  logic        w_load;
  logic [2:0]  w_load_len;
  logic [31:0] w_load_bytes;

  assign w_rsp_match = C2F_RspValidQ502H &&
                       (((r_op == RD) && (C2F_RspOpcodeQ502H == RD_RSP)) ||
                        ((r_op == WR) && (C2F_RspOpcodeQ502H == WR_RSP)));
  // Timeouts fire on the last allowed cycle and take priority over a same-cycle rx byte.
  assign w_byte_tmo  = ((r_state == ADDR) || (r_state == DATA)) && (r_byte_tmr == c_BT_FIRE);
  assign w_rsp_tmo   = (r_state == WAIT_RSP) && !w_rsp_match && (r_rsp_tmr == c_RT_FIRE);
  assign w_req_fire  = (r_state == REQ) && !C2F_RspStall;

  always_comb begin
    w_load       = 1'b0;
    w_load_len   = 3'd1;
    w_load_bytes = {UART_RPL_ERR, 24'h0};
    case (r_state)
      IDLE: begin
        if (rx_valid && (rx_data != UART_CMD_WR) && (rx_data != UART_CMD_RD)) begin
          w_load = 1'b1;
        end
      end
      ADDR, DATA: begin
        if (w_byte_tmo) begin
          w_load       = 1'b1;
          w_load_bytes = {UART_RPL_TMO, 24'h0};
        end
      end
      WAIT_RSP: begin
        if (w_rsp_match) begin
          w_load = 1'b1;
          if (r_op == RD) begin
            w_load_len   = 3'd4;
            w_load_bytes = C2F_RspDataQ502H;
          end else begin
            w_load_bytes = {UART_RPL_OK, 24'h0};
          end
        end else if (w_rsp_tmo) begin
          w_load       = 1'b1;
          w_load_bytes = {UART_RPL_TMO, 24'h0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_op       <= RD;
      r_addr     <= '0;
      r_data     <= '0;
      r_byte_cnt <= '0;
      r_byte_tmr <= '0;
      r_rsp_tmr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_byte_cnt <= '0;
          r_byte_tmr <= '0;
          if (rx_valid) begin
            if (rx_data == UART_CMD_WR || rx_data == UART_CMD_RD) begin
              r_op    <= (rx_data == UART_CMD_WR) ? WR : RD;
              r_addr  <= '0;
              r_data  <= '0;
              r_state <= ADDR;
            end else begin
              r_state <= TX;
            end
          end
        end
        ADDR, DATA: begin
          if (w_byte_tmo) begin
            r_state <= TX;
          end else if (rx_valid) begin
            r_byte_tmr <= '0;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_state == ADDR) r_addr <= {r_addr[23:0], rx_data};
            else                 r_data <= {r_data[23:0], rx_data};
            if (r_byte_cnt == 2'd3) begin
              r_state <= ((r_state == ADDR) && (r_op == WR)) ? DATA : REQ;
            end
          end else if (r_byte_tmr != c_BT_MAX) begin
            r_byte_tmr <= r_byte_tmr + c_BT_W'(1);
          end
        end
        REQ: begin
          r_rsp_tmr <= '0;
          if (w_req_fire) r_state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (w_rsp_match || w_rsp_tmo) begin
            r_state <= TX;
          end else if (r_rsp_tmr != c_RT_MAX) begin
            r_rsp_tmr <= r_rsp_tmr + c_RT_W'(1);
          end
        end
        TX: begin
          if (w_tx_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_reply_shifter u_reply (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .load_len   (w_load_len),
    .load_bytes (w_load_bytes),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .last_accept(w_tx_last),
    .cmd_done   (cmd_done)
  );

  // Valid is gated by stall directly so the request leaves on the first unstalled cycle.
  assign C2F_ReqValidQ500H    = w_req_fire;
  assign C2F_ReqOpcodeQ500H   = r_op;
  assign C2F_ReqAddressQ500H  = r_addr;
  assign C2F_ReqDataQ500H     = (r_op == WR) ? r_data : 32'h0;
  assign C2F_ReqThreadIDQ500H = THREAD_ID;
  assign busy                 = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command sequencer between the uart_io byte datapath and the fabric C2F port.
- Parses host terminal frames from the received byte stream:
  - Write frame: 'W' (0x57), 4 address bytes, 4 data bytes, all MSB byte first.
  - Read frame: 'R' (0x52), 4 address bytes, MSB byte first.
- For each frame it issues one C2F request, waits for the response and returns a status or data byte stream through the UART TX byte interface.
- Also enforces an inter-byte timeout, a response timeout and one-command-at-a-time ordering.

Parameters:
- BYTE_TIMEOUT, 200000: clk cycles allowed between bytes inside a frame (about 10 ms at 20 MHz).
- RSP_TIMEOUT, 1024: clk cycles allowed from request issue to C2F response.
- THREAD_ID, 2'd0: value driven on C2F_ReqThreadIDQ500H.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, received byte available
- rx_data  in  8  received byte
- tx_valid  out  1  byte to transmit is available
- tx_data  out  8  byte to transmit
- tx_ready  in  1  UART transmitter accepts tx_data when tx_valid && tx_ready
- C2F_ReqValidQ500H  out  1  fabric request valid (one cycle)
- C2F_ReqOpcodeQ500H  out  t_opcode  RD or WR
- C2F_ReqAddressQ500H  out  32  request address
- C2F_ReqDataQ500H  out  32  write data (0 for RD)
- C2F_ReqThreadIDQ500H  out  2  = THREAD_ID
- C2F_RspValidQ502H  in  1  response valid
- C2F_RspOpcodeQ502H  in  t_opcode  RD_RSP or WR_RSP
- C2F_RspDataQ502H  in  32  read data
- C2F_RspStall  in  1  fabric cannot accept a request this cycle
- cmd_done  out  1  one-cycle pulse when a command's reply has fully transmitted
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-high (rst).
- Reset values: every output is 0, state = IDLE, all counters and shift registers = 0. Asserting rst mid-operation aborts the frame immediately. The C2F request is not replayed, and no reply byte is sent.
- FSM states: IDLE, ADDR, DATA, REQ, WAIT_RSP, TX.
- IDLE:
  - rx 0x57 -> ADDR with op = WR.
  - rx 0x52 -> ADDR with op = RD.
  - Any other byte -> load reply '?' (0x3F) -> TX.
- ADDR:
  - Each rx byte does addr = {addr[23:0], byte}; a 2-bit byte counter is used.
  - After the 4th byte: WR -> DATA; RD -> REQ.
- DATA: same shift into data; after the 4th byte -> REQ.
- REQ:
  - If !C2F_RspStall, assert C2F_ReqValidQ500H for exactly one cycle with opcode, address, data and thread ID, then -> WAIT_RSP.
  - If stalled, stay in REQ with valid low.
- WAIT_RSP:
  - Accept C2F_RspValidQ502H only if the response opcode matches the request (RD_RSP for RD, WR_RSP for WR). Other responses are ignored.
  - RD response: load 4 reply bytes from RspData, MSB first.
  - WR response: load 1 reply byte 'K' (0x4B).
  - Response timeout: after RSP_TIMEOUT cycles without a match, load 'T' (0x54).
  - All three cases -> TX.
- TX:
  - tx_valid is held high with the current reply byte; tx_data is stable while tx_valid && !tx_ready.
  - The byte index advances on tx_valid && tx_ready.
  - After the last byte is accepted: pulse cmd_done, -> IDLE.
- Inter-byte timeout:
  - In ADDR or DATA, a counter clears on each rx_valid.
  - At BYTE_TIMEOUT the frame is discarded, reply 'T' -> TX.
- rx_valid in REQ, WAIT_RSP or TX is dropped silently; the host must wait for the reply.
- rx_valid in the same cycle as a timeout: the timeout wins and the byte is dropped.
- Latency:
  - Request valid is driven the cycle after the last frame byte, if no stall.
  - tx_valid is driven the cycle after the response is received.
- Counters are sized with $clog2(param+1); they saturate and do not wrap.

Decomposition:
- lotr_pkg holds:
  - t_opcode with enumerators RD, WR, RD_RSP, WR_RSP;
  - a new t_uart_cmd_state enum;
  - constants UART_CMD_WR=8'h57, UART_CMD_RD=8'h52, UART_RPL_OK=8'h4B, UART_RPL_ERR=8'h3F, UART_RPL_TMO=8'h54.
- One sub-module, uart_reply_shifter: a 4-entry byte buffer with a length and a valid/ready drain. It is loaded in parallel and emits cmd_done on its last accept.

Test Plan:
- Write: rx 57 12 34 56 78 DE AD BE EF.
  - Expect one C2F_ReqValid with WR, addr 0x12345678, data 0xDEADBEEF, tid 0.
  - Reply WR_RSP after 5 cycles -> tx 0x4B, then cmd_done.
- Read: rx 52 00 00 10 04.
  - Expect a RD request at addr 0x00001004 with data 0.
  - RD_RSP data 0xCAFEF00D -> tx CA FE F0 0D in order, with tx_ready toggling 1/0; bytes hold while not ready.
- Stall: hold C2F_RspStall=1 for 7 cycles after a read frame -> no request valid during the stall, exactly one valid on the first unstalled cycle.
- Timeouts:
  - Send 57 12 then go silent (BYTE_TIMEOUT=50) -> tx 0x54, no C2F request.
  - A read with no response (RSP_TIMEOUT=16) -> tx 0x54 after 16 cycles.
  - A following valid frame then completes normally.
- Error and filtering:
  - rx 0x41 in IDLE -> tx 0x3F.
  - A WR_RSP arriving while a read is pending is ignored; the following RD_RSP is used.
- Reset: assert rst during DATA (after 6 bytes) -> all outputs 0 asynchronously; no request or reply is issued; the next full write frame succeeds.
